// File: rtl/tetris_pkg.sv
// Shared tetris types and board geometry, plus the row overlap test used by
// both the fit checker and the lock/placement stage.
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int ROW_AW  = 5;

   typedef enum logic [2:0] {
      PIECE_I    = 3'd0,
      PIECE_J    = 3'd1,
      PIECE_L    = 3'd2,
      PIECE_O    = 3'd3,
      PIECE_S    = 3'd4,
      PIECE_T    = 3'd5,
      PIECE_Z    = 3'd6,
      PIECE_NONE = 3'd7
   } piece_code_t;

   typedef logic signed [4:0] pos_x_t;
   typedef logic signed [5:0] pos_y_t;

   typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} fit_state_t;

   function automatic logic signed [6:0] cellRow(input pos_y_t y, input logic [1:0] r);
      return $signed({y[5], y}) + $signed({5'b00000, r});
   endfunction

   // Rows off either end of the board read row 0; the checker never uses that data.
   function automatic logic [ROW_AW-1:0] boardAddr(input logic signed [6:0] row);
      if (row >= 7'sd0 && row < $signed(7'(BOARD_H)))
         return row[ROW_AW-1:0];
      return '0;
   endfunction

   // Cells above the board only collide if they are also off the side walls.
   function automatic logic rowCollides(input logic [3:0] shapeRow,
                                        input logic [BOARD_W-1:0] boardRow,
                                        input pos_x_t x,
                                        input logic signed [6:0] row);
      logic signed [6:0] col;
      logic [1:0] bitIdx;
      logic collide;
      collide = 1'b0;
      col = '0;
      for (int c = 0; c < 4; c++) begin
         bitIdx = 2'(3 - c);
         col = $signed({{2{x[4]}}, x}) + $signed(7'(c));
         if (shapeRow[bitIdx]) begin
            if (col < 7'sd0 || col >= $signed(7'(BOARD_W)) || row >= $signed(7'(BOARD_H)))
               collide = 1'b1;
            else if (row >= 7'sd0 && boardRow[col[3:0]])
               collide = 1'b1;
         end
      end
      return collide;
   endfunction

endpackage

// File: rtl/piece_fit_if.sv
// Query handshake between the game-control FSM (master) and the fit checker (slave).
interface piece_fit_if;
   import tetris_pkg::*;

   logic         start;
   logic [2:0]   code;
   logic [1:0]   rotate;
   pos_x_t       pos_x;
   pos_y_t       pos_y;
   logic         busy;
   logic         done;
   logic         fit;

   modport master (output start, code, rotate, pos_x, pos_y,
                   input  busy, done, fit);
   modport slave  (input  start, code, rotate, pos_x, pos_y,
                   output busy, done, fit);
endinterface

// File: rtl/piece_fit_checker.sv
// Walks the four shape rows of a piece against the board RAM, one FETCH/CHECK
// pair per row, and reports whether the piece fits at the requested position.
module piece_fit_checker #(
   parameter int BOARD_W = tetris_pkg::BOARD_W,
   parameter int BOARD_H = tetris_pkg::BOARD_H,
   parameter int ROW_AW  = tetris_pkg::ROW_AW
) (
   input  logic               Clk,
   input  logic               Reset,
   piece_fit_if.slave         req,
   output logic [6:0]         rom_addr,
   input  logic [3:0]         rom_data,
   output logic [ROW_AW-1:0]  board_row_addr,
   input  logic [BOARD_W-1:0] board_row_data
);
   import tetris_pkg::*;

   fit_state_t         r_state;
   logic [1:0]         r_row;
   logic [2:0]         r_code;
   logic [1:0]         r_rotate;
   pos_x_t             r_posX;
   pos_y_t             r_posY;
   logic               r_busy;
   logic               r_done;
   logic               r_fit;
   logic [6:0]         r_romAddr;
   logic [ROW_AW-1:0]  r_boardAddr;

   logic signed [6:0]  w_checkRow;
   logic [1:0]         w_nextRow;
   logic signed [6:0]  w_nextCellRow;
   logic signed [6:0]  w_firstCellRow;
   logic               w_collide;

   assign w_checkRow     = cellRow(r_posY, r_row);
   assign w_nextRow      = r_row + 2'd1;
   assign w_nextCellRow  = cellRow(r_posY, w_nextRow);
   assign w_firstCellRow = cellRow(req.pos_y, 2'd0);
   assign w_collide      = rowCollides(rom_data, board_row_data, r_posX, w_checkRow);

   assign req.busy       = r_busy;
   assign req.done       = r_done;
   assign req.fit        = r_fit;
   assign rom_addr       = r_romAddr;
   assign board_row_addr = r_boardAddr;

   // Addresses are registered on entry to FETCH so the synchronous board RAM
   // and the combinational ROM both present their rows during CHECK.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_row       <= '0;
         r_code      <= '0;
         r_rotate    <= '0;
         r_posX      <= '0;
         r_posY      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fit       <= 1'b0;
         r_romAddr   <= '0;
         r_boardAddr <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (req.start) begin
                  r_code   <= req.code;
                  r_rotate <= req.rotate;
                  r_posX   <= req.pos_x;
                  r_posY   <= req.pos_y;
                  r_fit    <= 1'b0;
                  r_row    <= '0;
                  if (req.code == PIECE_NONE) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= FETCH;
                     r_busy      <= 1'b1;
                     r_romAddr   <= {req.code, req.rotate, 2'b00};
                     r_boardAddr <= boardAddr(w_firstCellRow);
                  end
               end
            end
            FETCH: r_state <= CHECK;
            CHECK: begin
               if (w_collide || r_row == 2'd3) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_fit   <= ~w_collide;
               end else begin
                  r_state     <= FETCH;
                  r_row       <= w_nextRow;
                  r_romAddr   <= {r_code, r_rotate, w_nextRow};
                  r_boardAddr <= boardAddr(w_nextCellRow);
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piece_fit_checker.sv
// Directed checks of piece_fit_checker against a small shape ROM and board RAM
// model, with hand-computed fit results and done latencies.
module tb_piece_fit_checker;
   import tetris_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [6:0]  rom_addr;
   logic [3:0]  rom_data;
   logic [4:0]  board_row_addr;
   logic [9:0]  board_row_data;
   logic [9:0]  boardMem [20];

   int compared = 0;
   int mismatched = 0;

   piece_fit_if bus();

   piece_fit_checker dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .req            (bus),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .board_row_addr (board_row_addr),
      .board_row_data (board_row_data)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) board_row_data <= boardMem[board_row_addr];

   // Only the shapes exercised below; everything else reads as an empty row.
   function automatic logic [3:0] shapeRom(input logic [6:0] a);
      case (a)
         7'b000_00_01: return 4'b1111;
         7'b000_01_00, 7'b000_01_01,
         7'b000_01_10, 7'b000_01_11: return 4'b0010;
         7'b011_00_00, 7'b011_00_01: return 4'b0110;
         7'b101_00_00: return 4'b0100;
         7'b101_00_01: return 4'b1110;
         default: return 4'b0000;
      endcase
   endfunction

   assign rom_data = shapeRom(rom_addr);

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Returns at 1 time unit after the edge that samples start (cycle 1 sample point).
   task automatic applyStimulus(input logic [2:0] code, input logic [1:0] rot,
                                input logic signed [4:0] x, input logic signed [5:0] y);
      @(negedge Clk);
      bus.start  = 1'b1;
      bus.code   = code;
      bus.rotate = rot;
      bus.pos_x  = x;
      bus.pos_y  = y;
      @(posedge Clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic runQuery(input string tag, input logic [2:0] code, input logic [1:0] rot,
                           input logic signed [4:0] x, input logic signed [5:0] y,
                           input int expFit, input int expDone, input bit interfere);
      int doneAt = -1;
      int doneCount = 0;
      int busyCount = 0;
      int fitAtDone = -1;
      applyStimulus(code, rot, x, y);
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) begin
            @(posedge Clk);
            #1;
         end
         if (interfere && k == 3) begin
            bus.start  = 1'b1;
            bus.code   = 3'd0;
            bus.rotate = 2'd0;
            bus.pos_x  = 5'sd7;
            bus.pos_y  = 6'sd0;
         end
         if (interfere && k == 4) bus.start = 1'b0;
         if (bus.done) begin
            doneCount++;
            if (doneAt < 0) begin
               doneAt = k;
               fitAtDone = int'(bus.fit);
            end
         end
         if (bus.busy) busyCount++;
      end
      checkOutput({tag, "_doneCycle"}, doneAt, expDone);
      checkOutput({tag, "_doneCount"}, doneCount, 1);
      checkOutput({tag, "_fit"}, fitAtDone, expFit);
      checkOutput({tag, "_busyCycles"}, busyCount, expDone - 1);
      checkOutput({tag, "_fitHeld"}, int'(bus.fit), expFit);
   endtask

   initial begin
      int doneSeen;
      Reset = 1'b1;
      bus.start = 1'b0;
      bus.code = '0;
      bus.rotate = '0;
      bus.pos_x = '0;
      bus.pos_y = '0;
      for (int i = 0; i < 20; i++) boardMem[i] = '0;
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("reset_busy", int'(bus.busy), 0);
      checkOutput("reset_done", int'(bus.done), 0);
      checkOutput("reset_fit", int'(bus.fit), 0);
      checkOutput("reset_romAddr", int'(rom_addr), 0);
      checkOutput("reset_boardAddr", int'(board_row_addr), 0);
      Reset = 1'b0;

      runQuery("I_x3", 3'd0, 2'd0, 5'sd3, 6'sd0, 1, 9, 1'b0);
      runQuery("I_x7", 3'd0, 2'd0, 5'sd7, 6'sd0, 0, 5, 1'b0);

      boardMem[5] = 10'b0000010000;
      runQuery("T_x3", 3'd5, 2'd0, 5'sd3, 6'sd4, 0, 5, 1'b0);
      runQuery("T_x5", 3'd5, 2'd0, 5'sd5, 6'sd4, 1, 9, 1'b0);

      runQuery("O_floor", 3'd3, 2'd0, 5'sd0, 6'sd19, 0, 5, 1'b0);
      runQuery("I_top", 3'd0, 2'd1, -5'sd2, -6'sd2, 1, 9, 1'b0);
      runQuery("none", 3'd7, 2'd0, 5'sd0, 6'sd0, 0, 1, 1'b0);
      runQuery("ignoreStart", 3'd5, 2'd0, 5'sd5, 6'sd4, 1, 9, 1'b1);

      // Abort in CHECK(2): cycle 6 after start.
      applyStimulus(3'd5, 2'd0, 5'sd5, 6'sd4);
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("fetch1_romAddr", int'(rom_addr), 81);
      checkOutput("fetch1_boardAddr", int'(board_row_addr), 5);
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b1;
      @(posedge Clk);
      #1;
      checkOutput("abort_busy", int'(bus.busy), 0);
      checkOutput("abort_done", int'(bus.done), 0);
      checkOutput("abort_fit", int'(bus.fit), 0);
      checkOutput("abort_romAddr", int'(rom_addr), 0);
      checkOutput("abort_boardAddr", int'(board_row_addr), 0);
      Reset = 1'b0;
      doneSeen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge Clk);
         #1;
         if (bus.done) doneSeen++;
      end
      checkOutput("abort_noDone", doneSeen, 0);
      runQuery("afterAbort", 3'd5, 2'd0, 5'sd5, 6'sd4, 1, 9, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/piece_fit_checker.md
Name: piece_fit_checker

Overview:
Sequential collision checker that sits directly downstream of the tetromino shape ROM. It walks the 4 shape rows of a given piece/rotation at a candidate board position and compares them against the board occupancy RAM. It reports whether the piece fits, meaning it is in bounds and overlaps no occupied cell. The game-control FSM queries it before every move, rotate, spawn and drop step.

Parameters:
BOARD_W, 10, board width in cells (board row word width)
BOARD_H, 20, board height in rows
ROW_AW, 5, board row address width (ceil log2 BOARD_H)

Ports:
Clk  in  1  system clock; all state changes on rising edge
Reset  in  1  synchronous, active-high; one clock, sampled on Clk
start  in  1  request pulse; sampled only in IDLE
code  in  3  piece code 0..6 (I,J,L,O,S,T,Z); 7 is invalid
rotate  in  2  rotation index 0..3
pos_x  in  5  signed column of shape box column 0, range -2..9
pos_y  in  6  signed row of shape box row 0, range -3..19
rom_addr  out  7  {code, rotate, row[1:0]} to shape ROM
rom_data  in  4  shape row from ROM; combinational on rom_addr; bit 3 = box column 0
board_row_addr  out  ROW_AW  board RAM read address
board_row_data  in  BOARD_W  board row; valid 1 cycle after address (synchronous RAM); bit i = column i
busy  out  1  high from the cycle after accepted start until DONE
done  out  1  one-cycle pulse; result valid
fit  out  1  1 = piece fits; held from DONE until next accepted start

Behaviour:
- Reset: state=IDLE, busy=0, done=0, fit=0, rom_addr=0, board_row_addr=0, row counter=0.
- Start handling: IDLE with start=1 latches code/rotate/pos_x/pos_y and clears fit.
  - code=7: go straight to DONE with fit=0.
  - otherwise: go to FETCH with r=0.
- start outside IDLE: ignored; no queueing.
- FETCH(r): drive rom_addr={code_l,rotate_l,r}.
  - Drive board_row_addr = pos_y+r if 0 <= pos_y+r < BOARD_H, else 0.
  - Next state: CHECK(r).
- CHECK(r): rom_data and board_row_data are valid. For each shape bit c (0..3, bit 3-c) set:
  - col=pos_x+c and row=pos_y+r, signed, computed 7 bits wide, no wrap.
  - Collide if col<0, col>=BOARD_W, or row>=BOARD_H.
  - row<0 (above board) is never a collision on its own, and the board bit is not read.
  - Otherwise collide if board_row_data[col]=1.
  - Zero shape bits are never tested. An out-of-range position is legal if that box column/row is empty.
- After CHECK(r):
  - Any collision: DONE with fit=0 (early exit).
  - r==3 with no collision: DONE with fit=1.
  - Otherwise: FETCH(r+1).
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. fit is held.
- busy=1 in FETCH/CHECK only.
- Latency: start sampled at edge E0. Full check puts done in cycle 9 after E0 (8 cycles FETCH/CHECK + DONE). Collision in row r puts done in cycle 2r+3. Invalid code puts done in cycle 1.
- Outputs are registered or decoded from state only. No combinational path from start to done.
- Reset mid-operation aborts to IDLE with all outputs at reset values and no done pulse.

Decomposition:
- Shared tetris_pkg holds:
  - piece_code_t enum (I=0..Z=6, NONE=7)
  - BOARD_W, BOARD_H constants
  - pos_x_t/pos_y_t signed typedefs
  - fit_state_t enum {IDLE,FETCH,CHECK,DONE}
- Row bounds/overlap logic is one combinational function in the package, shared with the lock/placement stage.
- No sub-module. The shape ROM and board RAM are instantiated by the parent.

Test Plan:
- Empty board, code=0 rot=0 x=3 y=0 -> fit=1, done in cycle 9 after start, busy high cycles 1-8.
- Empty board, code=0 rot=0 x=7 y=0 (row1=1111 spans cols 7..10) -> fit=0, done in cycle 5.
- Board row5=10'b0000010000 (col4), code=5 rot=0 x=3 y=4 -> row1 cols3..5 hit col4 -> fit=0, done cycle 5. Same stimulus with x=5 -> fit=1.
- Floor and top:
  - code=3 y=19 x=0 -> shape row1 at board row 20 -> fit=0.
  - code=0 rot=1 x=-2 y=-2 (column x+2=0) -> fit=1, no board bits consulted for rows <0.
- code=7 -> done cycle 1, fit=0. Second start during busy ignored. Only one done pulse; fit matches first request.
- Reset asserted in CHECK(2) -> next cycle busy=0, done=0, fit=0. New start afterwards completes normally.
